// File: rtl/mmio_pkg.sv
// Shared register map and bit positions for the switch/LED MMIO block.
package mmio_pkg;

   localparam logic [1:0] ADDR_SW     = 2'd0;
   localparam logic [1:0] ADDR_LED    = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_BLINK  = 0;
   localparam int CTRL_FREEZE = 1;

   localparam int STAT_CHG   = 0;
   localparam int STAT_PHASE = 1;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debounce: a new switch value is accepted only
// after it has differed from the accepted value for CYCLES consecutive cycles.
module sw_debounce #(
   parameter int WIDTH  = 24,
   parameter int CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   input  logic             freeze,
   output logic [WIDTH-1:0] stable,
   output logic             accept_pulse
);

   localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter restarts whenever s2 matches the accepted value, so a short
   // glitch never reaches the terminal count.
   always_comb begin
      stable_d     = stable_q;
      cnt_d        = cnt_q;
      accept_pulse = 1'b0;
      if (freeze || (s2_q == stable_q)) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d     = s2_q;
         cnt_d        = '0;
         accept_pulse = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/mmio_switch_led.sv
// Memory-mapped switch/LED controller: debounced switch bank with sticky
// change flag, LED register with optional blink, registered read port.
module mmio_switch_led
   import mmio_pkg::*;
#(
   parameter int SW_WIDTH        = 24,
   parameter int LED_WIDTH       = 24,
   parameter int DATA_WIDTH      = 32,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int BLINK_BIT       = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            io_addr,
   input  logic                  io_rd,
   input  logic                  io_wr,
   input  logic [DATA_WIDTH-1:0] io_wdata,
   output logic [DATA_WIDTH-1:0] io_rdata,
   input  logic [SW_WIDTH-1:0]   switch_in,
   output logic [LED_WIDTH-1:0]  led_out,
   output logic                  sw_changed
);

   logic [SW_WIDTH-1:0]   sw_stable;
   logic                  sw_accept;

   logic [LED_WIDTH-1:0]  led_reg_q, led_reg_d;
   logic [LED_WIDTH-1:0]  led_out_q, led_out_d;
   logic [1:0]            ctrl_q, ctrl_d;
   logic                  chg_q, chg_d;
   logic [BLINK_BIT:0]    blink_cnt_q, blink_cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  phase;
   logic                  unused_wdata;

   sw_debounce #(
      .WIDTH  (SW_WIDTH),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk          (clk),
      .rst          (rst),
      .raw          (switch_in),
      .freeze       (ctrl_q[CTRL_FREEZE]),
      .stable       (sw_stable),
      .accept_pulse (sw_accept)
   );

   assign phase        = blink_cnt_q[BLINK_BIT];
   assign unused_wdata = ^io_wdata;

   // Read mux uses pre-edge state, so a read colliding with a write or a
   // flag set returns the old value.
   always_comb begin
      led_reg_d   = led_reg_q;
      ctrl_d      = ctrl_q;
      chg_d       = chg_q;
      rdata_d     = rdata_q;
      blink_cnt_d = blink_cnt_q + 1'b1;

      if (io_wr) begin
         case (io_addr)
            ADDR_LED:  led_reg_d = io_wdata[LED_WIDTH-1:0];
            ADDR_CTRL: ctrl_d    = io_wdata[1:0];
            default:   ;
         endcase
      end

      if (io_rd) begin
         rdata_d = '0;
         case (io_addr)
            ADDR_SW:   rdata_d[SW_WIDTH-1:0]  = sw_stable;
            ADDR_LED:  rdata_d[LED_WIDTH-1:0] = led_reg_q;
            ADDR_CTRL: rdata_d[1:0]           = ctrl_q;
            default: begin
               rdata_d[STAT_CHG]   = chg_q;
               rdata_d[STAT_PHASE] = phase;
               chg_d               = 1'b0;
            end
         endcase
      end

      // An acceptance in the same cycle as a clearing read keeps the flag set.
      if (sw_accept) begin
         chg_d = 1'b1;
      end

      led_out_d = (ctrl_q[CTRL_BLINK] && !phase) ? '0 : led_reg_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_reg_q   <= '0;
         led_out_q   <= '0;
         ctrl_q      <= '0;
         chg_q       <= 1'b0;
         blink_cnt_q <= '0;
         rdata_q     <= '0;
      end else begin
         led_reg_q   <= led_reg_d;
         led_out_q   <= led_out_d;
         ctrl_q      <= ctrl_d;
         chg_q       <= chg_d;
         blink_cnt_q <= blink_cnt_d;
         rdata_q     <= rdata_d;
      end
   end

   assign io_rdata   = rdata_q;
   assign led_out    = led_out_q;
   assign sw_changed = chg_q;

endmodule

// File: tb/tb_mmio_switch_led.sv
// Self-checking bench for mmio_switch_led with short debounce and blink period.
module tb_mmio_switch_led;

   localparam int SW_W = 24;
   localparam int LED_W = 24;
   localparam int DW = 32;
   localparam int DEB = 4;
   localparam int BB = 3;

   logic          clk;
   logic          rst;
   logic [1:0]    io_addr;
   logic          io_rd;
   logic          io_wr;
   logic [DW-1:0] io_wdata;
   logic [DW-1:0] io_rdata;
   logic [SW_W-1:0]  switch_in;
   logic [LED_W-1:0] led_out;
   logic          sw_changed;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int bcnt;
   logic [DW-1:0] exp_q[$];
   string         tag_q[$];

   mmio_switch_led #(
      .SW_WIDTH        (SW_W),
      .LED_WIDTH       (LED_W),
      .DATA_WIDTH      (DW),
      .DEBOUNCE_CYCLES (DEB),
      .BLINK_BIT       (BB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .io_addr    (io_addr),
      .io_rd      (io_rd),
      .io_wr      (io_wr),
      .io_wdata   (io_wdata),
      .io_rdata   (io_rdata),
      .switch_in  (switch_in),
      .led_out    (led_out),
      .sw_changed (sw_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference blink counter: number of edges since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) bcnt <= 0;
      else     bcnt <= bcnt + 1;
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [DW-1:0] exp_status(input logic chg);
      logic [DW-1:0] v;
      v = '0;
      v[0] = chg;
      v[1] = ((bcnt >> BB) & 1) != 0;
      return v;
   endfunction

   function automatic logic [LED_W-1:0] exp_blink_led(input logic [LED_W-1:0] led);
      return ((((bcnt - 1) >> BB) & 1) != 0) ? led : '0;
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
      io_addr  = a;
      io_wdata = d;
      io_wr    = 1'b1;
      @(negedge clk);
      io_wr    = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [DW-1:0] exp, input string tag);
      io_addr = a;
      io_rd   = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      io_rd = 1'b0;
      check_eq(tag_q.pop_front(), io_rdata, exp_q.pop_front());
   endtask

   initial begin
      int waited;
      rst = 1'b1;
      io_addr = '0; io_rd = 1'b0; io_wr = 1'b0; io_wdata = '0;
      switch_in = 24'hA5A5A5;

      // 1. reset and first acceptance
      #7000;
      check_eq("rst_led", DW'(led_out), '0);
      check_eq("rst_rdata", io_rdata, '0);
      check_eq("rst_chg", DW'(sw_changed), '0);
      @(negedge clk);
      rst = 1'b0;
      tick(5);
      check_eq("init_chg_early", DW'(sw_changed), '0);
      tick(1);
      check_eq("init_chg_set", DW'(sw_changed), 1);
      bus_read(2'd0, 32'h00A5A5A5, "init_sw");
      bus_read(2'd3, exp_status(1'b1), "init_status");
      check_eq("init_chg_clr", DW'(sw_changed), '0);

      // 2. debounce: return to zero, glitch, then a held value
      switch_in = '0;
      tick(8);
      bus_read(2'd3, exp_status(1'b1), "zero_status");
      switch_in = 24'h200001;
      tick(2);
      switch_in = '0;
      tick(10);
      check_eq("glitch_chg", DW'(sw_changed), '0);
      bus_read(2'd0, 32'h0, "glitch_sw");
      switch_in = 24'h200001;
      tick(5);
      check_eq("held_chg_early", DW'(sw_changed), '0);
      tick(1);
      check_eq("held_chg_set", DW'(sw_changed), 1);
      bus_read(2'd0, 32'h00200001, "held_sw");
      bus_read(2'd3, exp_status(1'b1), "held_status");

      // 3. LED write
      bus_write(2'd1, 32'hFF123456);
      check_eq("led_lag", DW'(led_out), '0);
      tick(1);
      check_eq("led_val", DW'(led_out), 32'h00123456);
      bus_read(2'd1, 32'h00123456, "led_rd");

      // 4. blink
      bus_write(2'd2, 32'h1);
      bus_write(2'd1, 32'h00FFFFFF);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check_eq("blink_led", DW'(led_out), DW'(exp_blink_led(24'hFFFFFF)));
      end
      bus_read(2'd3, exp_status(1'b0), "blink_status");
      check_eq("blink_phase_led", DW'(led_out), io_rdata[1] ? 32'h00FFFFFF : 32'h0);
      bus_read(2'd2, 32'h1, "ctrl_rd");
      bus_write(2'd2, 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check_eq("steady_led", DW'(led_out), 32'h00FFFFFF);
      end

      // 5. freeze, release and set-wins collision
      bus_write(2'd2, 32'h2);
      switch_in = 24'h000F00;
      tick(12);
      check_eq("frz_chg", DW'(sw_changed), '0);
      bus_read(2'd0, 32'h00200001, "frz_sw");
      bus_write(2'd2, 32'h0);
      tick(3);
      check_eq("unfrz_chg_early", DW'(sw_changed), '0);
      bus_read(2'd3, exp_status(1'b0), "collide_status");
      check_eq("collide_chg", DW'(sw_changed), 1);
      bus_read(2'd0, 32'h00000F00, "unfrz_sw");
      bus_read(2'd3, exp_status(1'b1), "unfrz_status");
      check_eq("unfrz_chg_clr", DW'(sw_changed), '0);

      // read/write same address: write applies, read returns old value
      io_addr = 2'd1; io_wdata = 32'h12ABCDEF; io_rd = 1'b1; io_wr = 1'b1;
      exp_q.push_back(32'h00FFFFFF);
      tag_q.push_back("rw_collide");
      @(negedge clk);
      io_rd = 1'b0; io_wr = 1'b0;
      check_eq(tag_q.pop_front(), io_rdata, exp_q.pop_front());
      bus_read(2'd1, 32'h00ABCDEF, "rw_after");
      bus_write(2'd0, 32'hFFFFFFFF);
      bus_read(2'd0, 32'h00000F00, "ro_sw_write");

      // 6. async reset while blinking with a pending debounce
      bus_write(2'd2, 32'h1);
      waited = 0;
      while (led_out == '0 && waited < 32) begin
         tick(1);
         waited++;
      end
      check_eq("blink_seen", DW'(led_out != '0), 1);
      switch_in = 24'h0F0F0F;
      bus_read(2'd1, 32'h00ABCDEF, "pre_rst_led");
      tick(1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_led", DW'(led_out), '0);
      check_eq("arst_rdata", io_rdata, '0);
      check_eq("arst_chg", DW'(sw_changed), '0);
      #20;
      @(negedge clk);
      rst = 1'b0;
      tick(5);
      check_eq("redeb_chg_early", DW'(sw_changed), '0);
      tick(1);
      check_eq("redeb_chg_set", DW'(sw_changed), 1);
      bus_read(2'd0, 32'h000F0F0F, "redeb_sw");
      bus_read(2'd2, 32'h0, "redeb_ctrl");
      bus_read(2'd1, 32'h0, "redeb_led");
      check_eq("redeb_led_out", DW'(led_out), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/mmio_switch_led.md
Name: mmio_switch_led

Overview:
Memory-mapped switch/LED I/O controller for the single-cycle CPU. It replaces the raw switch_in/led_out wiring with the following features:
- 2-flop synchroniser and debounce on the switch bank.
- A sticky change flag.
- A writable LED register with optional blink.
It sits between the CPU data-memory I/O decode and the board pins. Widths and timing are parametrised per board.

Parameters:
SW_WIDTH, 24, switch bank width (1..32)
LED_WIDTH, 24, LED bank width (1..32)
DATA_WIDTH, 32, CPU bus width
DEBOUNCE_CYCLES, 16, cycles a new switch value must stay stable before acceptance (>=2)
BLINK_BIT, 22, bit of free-running counter that gates LEDs in blink mode

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
io_addr  in  2  word offset: 0 SW_DATA(RO), 1 LED_DATA(RW), 2 CTRL(RW), 3 STATUS(RO)
io_rd  in  1  read strobe, one cycle
io_wr  in  1  write strobe, one cycle
io_wdata  in  DATA_WIDTH  write data
io_rdata  out  DATA_WIDTH  read data, registered
switch_in  in  SW_WIDTH  raw asynchronous switch pins
led_out  out  LED_WIDTH  LED pins, registered
sw_changed  out  1  level copy of STATUS[0], usable as interrupt

Behaviour:
- Reset (async, rst=1): all registers clear.
  - Cleared: sync flops, stable switch value, debounce counter, led_reg, CTRL, STATUS, blink counter.
  - Outputs during/after reset: io_rdata=0, led_out=0, sw_changed=0.
  - Reset mid-debounce discards the pending value.
- Synchroniser: switch_in -> s1 -> s2, two flops. s2 lags pins by 2 cycles.
- Debounce counter cnt, width clog2(DEBOUNCE_CYCLES):
  - s2==stable: cnt<=0.
  - s2!=stable and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0, STATUS[0]<=1.
  - Any s2 change while counting restarts comparison against stable; a glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Pin-to-SW_DATA latency: 2+DEBOUNCE_CYCLES cycles after the pins settle.
- Reads: io_rd at cycle N -> io_rdata valid at N+1 and held until the next io_rd.
  - SW_DATA: stable, zero-extended to DATA_WIDTH.
  - LED_DATA: led_reg, zero-extended.
  - CTRL: bits[1:0], rest zero.
  - STATUS: bit0 changed flag; bit1 = blink phase (counter[BLINK_BIT]).
- STATUS[0] is clear-on-read: an io_rd to addr 3 clears it at the clock edge.
  - If a debounce acceptance happens in the same cycle, set wins: the flag stays 1 and io_rdata shows the pre-edge value.
- Writes take effect at the clock edge of the io_wr cycle.
  - LED_DATA: led_reg<=io_wdata[LED_WIDTH-1:0], upper bits ignored.
  - CTRL: bit0 = blink_en, bit1 = freeze (while 1, stable is not updated; cnt holds at 0).
  - Writes to addresses 0 and 3 are ignored.
- Simultaneous io_rd and io_wr on the same address: the write is applied, and io_rdata returns the pre-write value.
- Blink counter: free-running, BLINK_BIT+1 bits, wraps to 0.
- led_out (registered, one cycle after led_reg/CTRL change):
  - blink_en=0: led_out = led_reg.
  - blink_en=1: led_out = led_reg when counter[BLINK_BIT]=1, else 0.
- sw_changed = STATUS[0], combinational from the flag register.

Decomposition:
- Shared package mmio_pkg holds:
  - address offset constants: ADDR_SW=0, ADDR_LED=1, ADDR_CTRL=2, ADDR_STATUS=3;
  - CTRL bit indices: CTRL_BLINK=0, CTRL_FREEZE=1;
  - STATUS bit indices: STAT_CHG=0, STAT_PHASE=1.
- One sub-module is natural: sw_debounce, parameters WIDTH and CYCLES.
  - Inputs: clk, rst, raw, freeze.
  - Outputs: stable, accept_pulse.
  - Contains the synchroniser and counter; top level holds the register file, blink logic and bus.

Test Plan:
1. Reset: rst=1 for 7000 ns with switch_in=24'hA5A5A5 -> led_out=0, io_rdata=0, sw_changed=0. Release rst, read SW_DATA -> 32'h00A5A5A5 after 2+DEBOUNCE_CYCLES cycles. sw_changed=1; it clears after a STATUS read that returns 1.
2. Debounce (DEBOUNCE_CYCLES=4): switch_in=0 -> 24'h200001 held 2 cycles, then back to 0 -> SW_DATA stays 0, sw_changed=0. Held 6 cycles -> SW_DATA=32'h00200001 exactly 6 cycles after the edge.
3. LED write: write LED_DATA=32'hFF123456 -> led_out=24'h123456 two edges later; read LED_DATA -> 32'h00123456.
4. Blink (BLINK_BIT=3): write CTRL=1, LED_DATA=24'hFFFFFF -> led_out alternates 24'hFFFFFF / 0 every 8 cycles, in phase with STATUS[1]. Write CTRL=0 -> steady 24'hFFFFFF.
5. Freeze and collision:
   - CTRL=2, toggle switches to 24'h000F00 -> SW_DATA unchanged.
   - Clear freeze -> accepted after DEBOUNCE_CYCLES.
   - STATUS read in the acceptance cycle -> io_rdata[0]=0, flag remains 1.
6. Async reset mid-operation: assert rst between clock edges while blinking with pending debounce -> led_out and io_rdata go to 0 immediately, without waiting for an edge. After release, the pending value is re-debounced from scratch.
